// File: rtl/raster_int_arbiter_if.sv
// Raster interrupt arbiter bus: event strobes, pixel tick, configuration,
// CPU acknowledge and the resulting interrupt request outputs.
// master = raster timing / CPU side, slave = the arbiter.
interface raster_int_arbiter_if;
  logic       c3;
  logic       frame_start;
  logic       int_start;
  logic       dma_end;
  logic [2:0] int_en;
  logic [7:0] int_len;
  logic       intack;
  logic       int_n;
  logic [7:0] int_vec;
  logic [2:0] int_pend;
  logic [2:0] int_ovf;

  modport master (
    output c3, frame_start, int_start, dma_end, int_en, int_len, intack,
    input  int_n, int_vec, int_pend, int_ovf
  );

  modport slave (
    input  c3, frame_start, int_start, dma_end, int_en, int_len, intack,
    output int_n, int_vec, int_pend, int_ovf
  );
endinterface

// File: rtl/raster_int_arbiter.sv
// Raster interrupt arbiter: collects frame, line and DMA events into pending
// flags, presents one source at a time to the CPU as a timed INT window
// (fixed priority frame > line > DMA, no preemption), then inserts a one
// c3-tick gap before the next window.
// Optional feature: define RASTER_INT_DMA_EN to enable the DMA source;
// without it the DMA source is tied off completely.
module raster_int_arbiter #(
  parameter logic [7:0] INT_LEN_DEF = 8'd32,
  parameter logic [7:0] VEC_FRM     = 8'hFF,
  parameter logic [7:0] VEC_LIN     = 8'hFD,
  parameter logic [7:0] VEC_DMA     = 8'hFB
) (
  input logic                  clk,
  input logic                  rst_n,
  raster_int_arbiter_if.slave  bus
);

`ifdef RASTER_INT_DMA_EN
  localparam logic [2:0] SRC_MASK = 3'b111;
`else
  localparam logic [2:0] SRC_MASK = 3'b011;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] ovf_q, ovf_d;
  logic [2:0] win_q;      // one-hot latched winner
  logic [7:0] cnt_q;      // c3 ticks elapsed in the current window
  logic [7:0] len_q;      // effective window length latched at window start
  logic [7:0] vec_q;
  logic       int_n_q;

  logic [2:0] en_eff;
  logic [2:0] ev;
  logic [2:0] ready;
  logic [2:0] grant;
  logic [2:0] fsm_clr;
  logic [2:0] clr;
  logic [7:0] len_sel;
  logic [7:0] vec_sel;
  logic       win_live;
  logic       timeout;
  logic       start;

  // Sources that are compiled out behave as permanently disabled.
  assign en_eff  = bus.int_en & SRC_MASK;
  assign ev      = {bus.dma_end, bus.int_start, bus.frame_start} & en_eff;
  assign len_sel = (bus.int_len == 8'd0) ? INT_LEN_DEF : bus.int_len;

  // Fixed priority: bit 0 (frame) wins, isolated as the lowest set bit.
  assign ready   = pend_q & en_eff;
  assign grant   = ready & (~ready + 3'd1);

  assign win_live = |(win_q & en_eff);
  // The edge that samples the len-th tick of the window closes it.
  assign timeout  = bus.c3 && ((cnt_q + 8'd1) == len_q);

  // Next-state logic.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|grant) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!win_live)                     state_d = ST_IDLE;
        else if (bus.intack || timeout)    state_d = ST_GAP;
      end
      ST_GAP:    if (bus.c3) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: window start and which pending flag the FSM retires.
  // intack takes precedence over a simultaneous timeout; only a frame
  // winner is retired by timeout, line and DMA keep requesting.
  always_comb begin
    start   = 1'b0;
    fsm_clr = 3'b000;
    unique case (state_q)
      ST_IDLE:   start = |grant;
      ST_ACTIVE: begin
        if (win_live) begin
          if (bus.intack)    fsm_clr = win_q;
          else if (timeout)  fsm_clr = win_q & 3'b001;
        end
      end
      default: ;
    endcase
  end

  // Vector for the source about to be granted.
  always_comb begin
    vec_sel = VEC_FRM;
    if (grant[1])                     vec_sel = VEC_LIN;
    else if (grant[2] && SRC_MASK[2]) vec_sel = VEC_DMA;
  end

  // Pending and overrun update. A disabled source is cleared; a new event
  // wins over a clear in the same cycle, and only counts as an overrun
  // when it hits a flag that stays set.
  assign clr    = fsm_clr | ~en_eff;
  assign pend_d = ev | (pend_q & ~clr);
  assign ovf_d  = ovf_q | (ev & pend_q & ~clr);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 3'b000;
      ovf_q   <= 3'b000;
      win_q   <= 3'b001;
      cnt_q   <= 8'd0;
      len_q   <= INT_LEN_DEF;
      vec_q   <= VEC_FRM;
      int_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      int_n_q <= (state_d != ST_ACTIVE);
      if (start) begin
        win_q <= grant;
        cnt_q <= 8'd0;
        len_q <= len_sel;
        vec_q <= vec_sel;
      end else if (state_q == ST_ACTIVE && bus.c3) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.int_n    = int_n_q;
  assign bus.int_vec  = vec_q;
  assign bus.int_pend = pend_q;
  assign bus.int_ovf  = ovf_q;

endmodule
